jedro_1_alu_arbiter: RTL and testbench

Shares the single registered-output ALU (jedro_1_alu, 1-cycle latency) between NUM_REQ requesters, e.g. the execute path and the branch/address unit. Uses round-robin arbitration on a valid/ready request interface. Each ALU result is routed back to the requester that issued it, through a per-requester single-entry response buffer with valid/ready backpressure. The block sits between the requesters and the ALU instance and owns the ALU input ports.

---
 rtl/jedro_1_alu_arbiter_pkg.sv | 33 +++
 rtl/jedro_1_alu_arbiter_rr.sv | 34 +++
 rtl/jedro_1_alu_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_jedro_1_alu_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jedro_1_alu_arbiter_pkg.sv
// Shared widths, ALU opcode constants and arbiter helpers for the ALU arbiter
// slice. Opcodes follow the {funct7[5], funct3} encoding used by jedro_1_alu.
package jedro_1_alu_arbiter_pkg;

    localparam int DATA_WIDTH       = 32;
    localparam int ALU_OP_WIDTH     = 4;
    localparam int REG_ADDR_WIDTH   = 5;

    localparam int ALU_ARB_MAX_REQ  = 4;
    localparam int ALU_ARB_ID_WIDTH = 2;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = 4'b0000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = 4'b1000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = 4'b0001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = 4'b0010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = 4'b0011;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = 4'b0100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = 4'b0101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = 4'b1101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = 4'b0110;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = 4'b0111;

    typedef logic [ALU_ARB_ID_WIDTH-1:0] arb_id_t;

    // Successor of a requester id, wrapping at num_req.
    function automatic arb_id_t arb_next_id(input arb_id_t id, input int num_req);
        if (int'(id) >= num_req - 1) begin
            return '0;
        end
        return id + arb_id_t'(1);
    endfunction

endpackage

// File: rtl/jedro_1_alu_arbiter_rr.sv
// Combinational round-robin picker: grants the first requesting index found
// scanning upward from ptr_i with wrap-around. Holds no state.
module jedro_1_rr_arbiter
    import jedro_1_alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [ALU_ARB_ID_WIDTH-1:0] ptr_i,
    output logic [NUM_REQ-1:0]          grant_o,
    output logic [ALU_ARB_ID_WIDTH-1:0] grant_id_o
);

    // Walk offsets 0..NUM_REQ-1 from the pointer; the first hit wins.
    always_comb begin
        logic found;
        int   idx;
        grant_o    = '0;
        grant_id_o = '0;
        found      = 1'b0;
        idx        = 0;
        for (int o = 0; o < NUM_REQ; o++) begin
            idx = (int'(ptr_i) + o) % NUM_REQ;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && (k == idx) && req_i[k]) begin
                    found      = 1'b1;
                    grant_o[k] = 1'b1;
                    grant_id_o = ALU_ARB_ID_WIDTH'(k);
                end
            end
        end
    end

endmodule

// File: rtl/jedro_1_alu_arbiter.sv
// Shares one registered-output ALU among NUM_REQ requesters. Requests are
// picked round-robin; each result is steered back into a single-entry response
// buffer owned by the requester that issued it.
module jedro_1_alu_arbiter
    import jedro_1_alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,

    input  logic [NUM_REQ-1:0]                 req_valid_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    input  logic [NUM_REQ*ALU_OP_WIDTH-1:0]    req_sel_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_op_a_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_op_b_i,
    input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]  req_dest_addr_i,
    input  logic [NUM_REQ-1:0]                 req_wb_i,

    output logic [ALU_OP_WIDTH-1:0]            alu_sel_o,
    output logic [DATA_WIDTH-1:0]              alu_op_a_o,
    output logic [DATA_WIDTH-1:0]              alu_op_b_o,
    output logic [REG_ADDR_WIDTH-1:0]          alu_dest_addr_o,
    output logic                               alu_wb_o,

    input  logic [DATA_WIDTH-1:0]              alu_res_i,
    input  logic                               alu_ops_eq_i,
    input  logic                               alu_overflow_i,
    input  logic [REG_ADDR_WIDTH-1:0]          alu_dest_addr_i,
    input  logic                               alu_wb_i,

    output logic [NUM_REQ-1:0]                 rsp_valid_o,
    input  logic [NUM_REQ-1:0]                 rsp_ready_i,
    output logic [NUM_REQ*DATA_WIDTH-1:0]      rsp_res_o,
    output logic [NUM_REQ-1:0]                 rsp_ops_eq_o,
    output logic [NUM_REQ-1:0]                 rsp_overflow_o,
    output logic [NUM_REQ*REG_ADDR_WIDTH-1:0]  rsp_dest_addr_o,
    output logic [NUM_REQ-1:0]                 rsp_wb_o
);

    localparam int IDW = ALU_ARB_ID_WIDTH;
    localparam int DW  = DATA_WIDTH;
    localparam int OW  = ALU_OP_WIDTH;
    localparam int AW  = REG_ADDR_WIDTH;

    logic [IDW-1:0]         rr_ptr_q,   rr_ptr_d;
    logic                   infl_vld_q, infl_vld_d;
    logic [IDW-1:0]         infl_id_q,  infl_id_d;

    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ*DW-1:0]  rsp_res_q,   rsp_res_d;
    logic [NUM_REQ-1:0]     rsp_eq_q,    rsp_eq_d;
    logic [NUM_REQ-1:0]     rsp_ovf_q,   rsp_ovf_d;
    logic [NUM_REQ*AW-1:0]  rsp_dest_q,  rsp_dest_d;
    logic [NUM_REQ-1:0]     rsp_wb_q,    rsp_wb_d;

    logic [NUM_REQ-1:0]     elig;
    logic [NUM_REQ-1:0]     grant;
    logic [IDW-1:0]         grant_id;
    logic                   grant_any;

    // A requester may issue if its previous op is not still in the ALU and its
    // response buffer is empty or being drained this cycle, so a capture can
    // never land on undrained data.
    always_comb begin
        elig = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            elig[k] = req_valid_i[k]
                    & ~(infl_vld_q & (infl_id_q == IDW'(k)))
                    & (~rsp_valid_q[k] | rsp_ready_i[k]);
        end
    end

    jedro_1_rr_arbiter #(
        .NUM_REQ    (NUM_REQ)
    ) u_rr_arbiter (
        .req_i      (elig),
        .ptr_i      (rr_ptr_q),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    assign grant_any   = |grant;
    assign req_ready_o = grant;

    // Steer the granted requester's operands onto the ALU; park it on a
    // harmless ADD of zeros with writeback off when nobody is granted.
    always_comb begin
        alu_sel_o       = ALU_OP_ADD;
        alu_op_a_o      = '0;
        alu_op_b_o      = '0;
        alu_dest_addr_o = '0;
        alu_wb_o        = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                alu_sel_o       = req_sel_i[k*OW +: OW];
                alu_op_a_o      = req_op_a_i[k*DW +: DW];
                alu_op_b_o      = req_op_b_i[k*DW +: DW];
                alu_dest_addr_o = req_dest_addr_i[k*AW +: AW];
                alu_wb_o        = req_wb_i[k];
            end
        end
    end

    // Remember who owns the op now entering the ALU and advance the pointer
    // past the winner so the others get priority next.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        infl_vld_d = grant_any;
        infl_id_d  = infl_id_q;
        if (grant_any) begin
            rr_ptr_d  = arb_next_id(grant_id, NUM_REQ);
            infl_id_d = grant_id;
        end
    end

    // Drain consumed responses, then capture the ALU result into its owner's
    // buffer; capture is applied last so it wins over a same-cycle drain.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_res_d   = rsp_res_q;
        rsp_eq_d    = rsp_eq_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_dest_d  = rsp_dest_q;
        rsp_wb_d    = rsp_wb_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (rsp_valid_q[k] && rsp_ready_i[k]) begin
                rsp_valid_d[k] = 1'b0;
            end
            if (infl_vld_q && (infl_id_q == IDW'(k))) begin
                rsp_valid_d[k]          = 1'b1;
                rsp_res_d[k*DW +: DW]   = alu_res_i;
                rsp_eq_d[k]             = alu_ops_eq_i;
                rsp_ovf_d[k]            = alu_overflow_i;
                rsp_dest_d[k*AW +: AW]  = alu_dest_addr_i;
                rsp_wb_d[k]             = alu_wb_i;
            end
        end
    end

    // Arbitration and in-flight tracking registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rr_ptr_q   <= '0;
            infl_vld_q <= 1'b0;
            infl_id_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            infl_vld_q <= infl_vld_d;
            infl_id_q  <= infl_id_d;
        end
    end

    // Response buffers; reset clears contents as well as the valid flags.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rsp_valid_q <= '0;
            rsp_res_q   <= '0;
            rsp_eq_q    <= '0;
            rsp_ovf_q   <= '0;
            rsp_dest_q  <= '0;
            rsp_wb_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_eq_q    <= rsp_eq_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_dest_q  <= rsp_dest_d;
            rsp_wb_q    <= rsp_wb_d;
        end
    end

    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_res_o       = rsp_res_q;
    assign rsp_ops_eq_o    = rsp_eq_q;
    assign rsp_overflow_o  = rsp_ovf_q;
    assign rsp_dest_addr_o = rsp_dest_q;
    assign rsp_wb_o        = rsp_wb_q;

endmodule

// File: tb/tb_jedro_1_alu_arbiter.sv
// Bench for jedro_1_alu_arbiter with two requesters and a small registered ALU
// stand-in. The driver issues directed cycles and queues expectations; the
// monitor pops and compares them on the falling edge.
module tb_jedro_1_alu_arbiter;
    import jedro_1_alu_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int DW = DATA_WIDTH;
    localparam int OW = ALU_OP_WIDTH;
    localparam int AW = REG_ADDR_WIDTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready_o;
    logic [N*OW-1:0]   req_sel;
    logic [N*DW-1:0]   req_a;
    logic [N*DW-1:0]   req_b;
    logic [N*AW-1:0]   req_dest;
    logic [N-1:0]      req_wb;

    logic [OW-1:0]     alu_sel_o;
    logic [DW-1:0]     alu_op_a_o;
    logic [DW-1:0]     alu_op_b_o;
    logic [AW-1:0]     alu_dest_addr_o;
    logic              alu_wb_o;

    logic [DW-1:0]     alu_res_r;
    logic              alu_eq_r;
    logic              alu_ovf_r;
    logic [AW-1:0]     alu_dest_r;
    logic              alu_wb_r;

    logic [N-1:0]      rsp_valid_o;
    logic [N-1:0]      rsp_ready;
    logic [N*DW-1:0]   rsp_res_o;
    logic [N-1:0]      rsp_ops_eq_o;
    logic [N-1:0]      rsp_overflow_o;
    logic [N*AW-1:0]   rsp_dest_addr_o;
    logic [N-1:0]      rsp_wb_o;

    jedro_1_alu_arbiter #(.NUM_REQ(N)) dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready_o),
        .req_sel_i       (req_sel),
        .req_op_a_i      (req_a),
        .req_op_b_i      (req_b),
        .req_dest_addr_i (req_dest),
        .req_wb_i        (req_wb),
        .alu_sel_o       (alu_sel_o),
        .alu_op_a_o      (alu_op_a_o),
        .alu_op_b_o      (alu_op_b_o),
        .alu_dest_addr_o (alu_dest_addr_o),
        .alu_wb_o        (alu_wb_o),
        .alu_res_i       (alu_res_r),
        .alu_ops_eq_i    (alu_eq_r),
        .alu_overflow_i  (alu_ovf_r),
        .alu_dest_addr_i (alu_dest_r),
        .alu_wb_i        (alu_wb_r),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready),
        .rsp_res_o       (rsp_res_o),
        .rsp_ops_eq_o    (rsp_ops_eq_o),
        .rsp_overflow_o  (rsp_overflow_o),
        .rsp_dest_addr_o (rsp_dest_addr_o),
        .rsp_wb_o        (rsp_wb_o)
    );

    // Registered ALU stand-in: one cycle from inputs to outputs.
    function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] s, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (s)
            ALU_OP_ADD:  return a + b;
            ALU_OP_SUB:  return a - b;
            ALU_OP_XOR:  return a ^ b;
            ALU_OP_OR:   return a | b;
            ALU_OP_AND:  return a & b;
            ALU_OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default:     return '0;
        endcase
    endfunction

    function automatic logic ovf_f(input logic [OW-1:0] s, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        if (s == ALU_OP_ADD) begin
            r = a + b;
            return (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
        end
        if (s == ALU_OP_SUB) begin
            r = a - b;
            return (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
        end
        return 1'b0;
    endfunction

    always_ff @(posedge clk) begin
        alu_res_r  <= alu_f(alu_sel_o, alu_op_a_o, alu_op_b_o);
        alu_eq_r   <= (alu_op_a_o == alu_op_b_o);
        alu_ovf_r  <= ovf_f(alu_sel_o, alu_op_a_o, alu_op_b_o);
        alu_dest_r <= alu_dest_addr_o;
        alu_wb_r   <= alu_wb_o;
    end

    typedef struct packed {
        logic [DW-1:0] res;
        logic          eq;
        logic          ovf;
        logic [AW-1:0] dest;
        logic          wb;
    } rsp_t;

    typedef struct {
        logic [N-1:0] rdy;
        logic [N-1:0] vld;
        logic         idle;
        int           tag;
    } cyc_t;

    cyc_t exp_q[$];
    rsp_t rsp_q0[$];
    rsp_t rsp_q1[$];

    int   checks;
    int   errors;
    logic fin;

    cyc_t ce;
    rsp_t got_r;
    rsp_t er;
    logic have;

    task automatic setreq(input int i, input logic [OW-1:0] s, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [AW-1:0] d, input logic w);
        req_sel[i*OW +: OW]  = s;
        req_a[i*DW +: DW]    = a;
        req_b[i*DW +: DW]    = b;
        req_dest[i*AW +: AW] = d;
        req_wb[i]            = w;
    endtask

    task automatic exp_rsp(input int i, input logic [DW-1:0] res, input logic eq,
                           input logic ovf, input logic [AW-1:0] d, input logic w);
        rsp_t r;
        r.res = res; r.eq = eq; r.ovf = ovf; r.dest = d; r.wb = w;
        if (i == 0) rsp_q0.push_back(r);
        else        rsp_q1.push_back(r);
    endtask

    // One clock cycle of stimulus plus the cycle's expected ready/valid vectors.
    task automatic tick(input logic r, input logic [N-1:0] v, input logic [N-1:0] rr,
                        input logic [N-1:0] e_rdy, input logic [N-1:0] e_vld,
                        input logic idle, input int tag);
        cyc_t c;
        @(posedge clk);
        #1;
        rstn      = r;
        req_valid = v;
        rsp_ready = rr;
        c.rdy = e_rdy; c.vld = e_vld; c.idle = idle; c.tag = tag;
        exp_q.push_back(c);
    endtask

    // Monitor: per-cycle handshake checks and response scoreboard.
    initial begin
        checks = 0;
        errors = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                ce = exp_q.pop_front();
                checks++;
                if (req_ready_o !== ce.rdy) begin
                    errors++;
                    $display("FAIL c%0d req_ready: got %b expected %b", ce.tag, req_ready_o, ce.rdy);
                end
                checks++;
                if (rsp_valid_o !== ce.vld) begin
                    errors++;
                    $display("FAIL c%0d rsp_valid: got %b expected %b", ce.tag, rsp_valid_o, ce.vld);
                end
                if (ce.idle) begin
                    checks++;
                    if ({alu_sel_o, alu_op_a_o, alu_op_b_o, alu_dest_addr_o, alu_wb_o} !==
                        {ALU_OP_ADD, {DW{1'b0}}, {DW{1'b0}}, {AW{1'b0}}, 1'b0}) begin
                        errors++;
                        $display("FAIL c%0d alu_idle: got sel=%h a=%h b=%h dest=%h wb=%b expected add/zeros",
                                 ce.tag, alu_sel_o, alu_op_a_o, alu_op_b_o, alu_dest_addr_o, alu_wb_o);
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (rstn && rsp_valid_o[i] && rsp_ready[i]) begin
                    got_r = {rsp_res_o[i*DW +: DW], rsp_ops_eq_o[i], rsp_overflow_o[i],
                             rsp_dest_addr_o[i*AW +: AW], rsp_wb_o[i]};
                    have = 1'b0;
                    er   = '0;
                    if (i == 0 && rsp_q0.size() > 0) begin er = rsp_q0.pop_front(); have = 1'b1; end
                    if (i == 1 && rsp_q1.size() > 0) begin er = rsp_q1.pop_front(); have = 1'b1; end
                    checks++;
                    if (!have) begin
                        errors++;
                        $display("FAIL rsp%0d unexpected: got res=%h eq=%b ovf=%b dest=%0d wb=%b expected none",
                                 i, got_r.res, got_r.eq, got_r.ovf, got_r.dest, got_r.wb);
                    end else if (got_r !== er) begin
                        errors++;
                        $display("FAIL rsp%0d data: got res=%h eq=%b ovf=%b dest=%0d wb=%b expected res=%h eq=%b ovf=%b dest=%0d wb=%b",
                                 i, got_r.res, got_r.eq, got_r.ovf, got_r.dest, got_r.wb,
                                 er.res, er.eq, er.ovf, er.dest, er.wb);
                    end
                end
            end
            if (fin && exp_q.size() == 0) begin
                checks++;
                if (rsp_q0.size() + rsp_q1.size() != 0) begin
                    errors++;
                    $display("FAIL leftover_rsp: got %0d/%0d undelivered expected 0/0",
                             rsp_q0.size(), rsp_q1.size());
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    // Driver: directed scenarios, cycle by cycle.
    initial begin
        fin       = 1'b0;
        rstn      = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_sel   = '0;
        req_a     = '0;
        req_b     = '0;
        req_dest  = '0;
        req_wb    = '0;
        repeat (3) @(posedge clk);

        // Reset state and idle: nothing granted, ALU parked, no responses.
        tick(1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 60);
        tick(1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 61);
        tick(1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 62);

        // Single request: 5+7 -> 12, response two cycles after the grant.
        setreq(0, ALU_OP_ADD, 32'd5, 32'd7, 5'd3, 1'b1);
        tick(1'b1, 2'b01, 2'b11, 2'b01, 2'b00, 1'b0, 10); exp_rsp(0, 32'd12, 1'b0, 1'b0, 5'd3, 1'b1);
        tick(1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 11);
        tick(1'b1, 2'b00, 2'b11, 2'b00, 2'b01, 1'b0, 12);
        tick(1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 13);

        // Both requesters streaming: grants alternate, ALU busy every cycle.
        setreq(0, ALU_OP_SUB, 32'd10, 32'd3, 5'd1, 1'b1);
        setreq(1, ALU_OP_XOR, 32'hF0, 32'h0F, 5'd2, 1'b1);
        tick(1'b1, 2'b11, 2'b11, 2'b10, 2'b00, 1'b0, 20); exp_rsp(1, 32'hFF, 1'b0, 1'b0, 5'd2, 1'b1);
        tick(1'b1, 2'b11, 2'b11, 2'b01, 2'b00, 1'b0, 21); exp_rsp(0, 32'd7,  1'b0, 1'b0, 5'd1, 1'b1);
        tick(1'b1, 2'b11, 2'b11, 2'b10, 2'b10, 1'b0, 22); exp_rsp(1, 32'hFF, 1'b0, 1'b0, 5'd2, 1'b1);
        tick(1'b1, 2'b11, 2'b11, 2'b01, 2'b01, 1'b0, 23); exp_rsp(0, 32'd7,  1'b0, 1'b0, 5'd1, 1'b1);
        tick(1'b1, 2'b11, 2'b11, 2'b10, 2'b10, 1'b0, 24); exp_rsp(1, 32'hFF, 1'b0, 1'b0, 5'd2, 1'b1);
        tick(1'b1, 2'b11, 2'b11, 2'b01, 2'b01, 1'b0, 25); exp_rsp(0, 32'd7,  1'b0, 1'b0, 5'd1, 1'b1);
        tick(1'b1, 2'b00, 2'b11, 2'b00, 2'b10, 1'b1, 26);
        tick(1'b1, 2'b00, 2'b11, 2'b00, 2'b01, 1'b1, 27);
        tick(1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 28);

        // Requester 1 backpressured: blocked until its buffer drains, then
        // regranted in the drain cycle; requester 0 keeps issuing.
        setreq(0, ALU_OP_ADD, 32'd1, 32'd1, 5'd4, 1'b0);
        setreq(1, ALU_OP_OR,  32'h30, 32'h03, 5'd5, 1'b1);
        tick(1'b1, 2'b11, 2'b01, 2'b10, 2'b00, 1'b0, 30); exp_rsp(1, 32'h33, 1'b0, 1'b0, 5'd5, 1'b1);
        tick(1'b1, 2'b11, 2'b01, 2'b01, 2'b00, 1'b0, 31); exp_rsp(0, 32'd2,  1'b1, 1'b0, 5'd4, 1'b0);
        tick(1'b1, 2'b11, 2'b01, 2'b00, 2'b10, 1'b1, 32);
        tick(1'b1, 2'b11, 2'b01, 2'b01, 2'b11, 1'b0, 33); exp_rsp(0, 32'd2,  1'b1, 1'b0, 5'd4, 1'b0);
        tick(1'b1, 2'b11, 2'b01, 2'b00, 2'b10, 1'b1, 34);
        tick(1'b1, 2'b11, 2'b01, 2'b01, 2'b11, 1'b0, 35); exp_rsp(0, 32'd2,  1'b1, 1'b0, 5'd4, 1'b0);
        tick(1'b1, 2'b11, 2'b11, 2'b10, 2'b10, 1'b0, 36); exp_rsp(1, 32'h33, 1'b0, 1'b0, 5'd5, 1'b1);
        tick(1'b1, 2'b11, 2'b11, 2'b01, 2'b01, 1'b0, 37); exp_rsp(0, 32'd2,  1'b1, 1'b0, 5'd4, 1'b0);
        tick(1'b1, 2'b00, 2'b11, 2'b00, 2'b10, 1'b1, 38);
        tick(1'b1, 2'b00, 2'b11, 2'b00, 2'b01, 1'b1, 39);
        tick(1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 40);

        // Single requester, ready tied high: drain and reissue in the same
        // cycle, buffer data replaced by the next result (SLTU then ADD overflow).
        setreq(0, ALU_OP_SLTU, 32'd1, 32'hFFFF_FFFF, 5'd6, 1'b1);
        tick(1'b1, 2'b01, 2'b11, 2'b01, 2'b00, 1'b0, 41); exp_rsp(0, 32'd1, 1'b0, 1'b0, 5'd6, 1'b1);
        tick(1'b1, 2'b01, 2'b11, 2'b00, 2'b00, 1'b1, 42);
        setreq(0, ALU_OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd7, 1'b0);
        tick(1'b1, 2'b01, 2'b11, 2'b01, 2'b01, 1'b0, 43); exp_rsp(0, 32'h8000_0000, 1'b0, 1'b1, 5'd7, 1'b0);
        tick(1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 44);
        tick(1'b1, 2'b00, 2'b11, 2'b00, 2'b01, 1'b1, 45);
        tick(1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 46);

        // Reset with a result in flight: it is dropped and the pointer
        // restarts at requester 0.
        setreq(0, ALU_OP_ADD, 32'd2, 32'd2, 5'd8, 1'b1);
        setreq(1, ALU_OP_ADD, 32'd3, 32'd3, 5'd9, 1'b1);
        tick(1'b1, 2'b01, 2'b11, 2'b01, 2'b00, 1'b0, 50);
        tick(1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 51);
        tick(1'b1, 2'b11, 2'b11, 2'b01, 2'b00, 1'b0, 52); exp_rsp(0, 32'd4, 1'b1, 1'b0, 5'd8, 1'b1);
        tick(1'b1, 2'b11, 2'b11, 2'b10, 2'b00, 1'b0, 53); exp_rsp(1, 32'd6, 1'b1, 1'b0, 5'd9, 1'b1);
        tick(1'b1, 2'b00, 2'b11, 2'b00, 2'b01, 1'b1, 54);
        tick(1'b1, 2'b00, 2'b11, 2'b00, 2'b10, 1'b1, 55);
        tick(1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 56);

        fin = 1'b1;
        repeat (10) @(posedge clk);
        $display("FAIL end_of_test: got no summary expected summary within 10 cycles");
        $fatal(1, "bench did not reach its summary");
    end

    // Global time bound.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "time limit reached");
    end

endmodule
